// File: rtl/mipi_payload_framer.sv
// Transmit-side payload framer for the MIPI TX pixel path.
// Holds one DLEN-bit payload and streams it as 48-bit pixel words:
// MARKER, {word count, sequence}, payload words (LSB first), XOR checksum.
module mipi_payload_framer #(
    parameter int          DLEN   = 512,
    parameter logic [47:0] MARKER = 48'hA0B0C0A0B0C0
) (
    input  logic            tx_pixel_clk,
    input  logic            rst,
    input  logic [DLEN-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            frame_start,
    input  logic            pix_req,
    output logic [63:0]     out_data,
    output logic            busy,
    output logic            frame_done,
    output logic [31:0]     seq
);

    localparam int NWORDS = (DLEN + 47) / 48;
    localparam int PW     = NWORDS * 48;
    localparam int IW     = $clog2(NWORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_HDR,
        S_LEN,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [PW-1:0]   r_buffer;
    logic [47:0]     r_outData;
    logic [47:0]     r_csum;
    logic [31:0]     r_seq;
    logic [IW-1:0]   r_wordIdx;
    logic [47:0]     w_word;
    logic            w_lastWord;

    // Once the index has walked past the final payload word, the next consumed word is the checksum.
    assign w_lastWord = (r_wordIdx == IW'(NWORDS));

    assign in_ready   = (r_state == S_IDLE) && !rst;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_CSUM) && pix_req;
    assign out_data   = {16'h0000, r_outData};
    assign seq        = r_seq;

    // State register; reset drops any frame in flight straight back to idle.
    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: header/payload/checksum states only advance on a consumed pixel.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:     if (in_valid)                w_nextState = S_WAIT_SOF;
            S_WAIT_SOF: if (frame_start)             w_nextState = S_HDR;
            S_HDR:      if (pix_req)                 w_nextState = S_LEN;
            S_LEN:      if (pix_req)                 w_nextState = S_PAYLOAD;
            S_PAYLOAD:  if (pix_req && w_lastWord)   w_nextState = S_CSUM;
            S_CSUM:     if (pix_req)                 w_nextState = S_IDLE;
            default:                                 w_nextState = S_IDLE;
        endcase
    end

    // Select the payload word addressed by the word index out of the zero-padded buffer.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (r_wordIdx == IW'(k)) begin
                w_word = r_buffer[k*48 +: 48];
            end
        end
    end

    // Datapath: payload capture, sequence counting, output word register and running checksum.
    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            r_buffer  <= '0;
            r_outData <= '0;
            r_csum    <= '0;
            r_seq     <= '0;
            r_wordIdx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_outData <= '0;
                    if (in_valid) begin
                        r_buffer <= PW'(in_data);
                    end
                end
                S_WAIT_SOF: begin
                    if (frame_start) begin
                        r_outData <= MARKER;
                        r_seq     <= r_seq + 32'd1;
                    end
                end
                S_HDR: begin
                    if (pix_req) begin
                        r_outData <= {16'(NWORDS), r_seq};
                        r_wordIdx <= '0;
                    end
                end
                S_LEN: begin
                    if (pix_req) begin
                        r_outData <= w_word;
                        r_csum    <= w_word;
                        r_wordIdx <= IW'(1);
                    end
                end
                S_PAYLOAD: begin
                    if (pix_req) begin
                        if (w_lastWord) begin
                            r_outData <= r_csum;
                        end else begin
                            r_outData <= w_word;
                            r_csum    <= r_csum ^ w_word;
                            r_wordIdx <= r_wordIdx + IW'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (pix_req) begin
                        r_outData <= '0;
                    end
                end
                default: begin
                    r_outData <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_payload_framer.sv
// Self-checking bench for mipi_payload_framer: randomized pixel stalls, noisy start strobes
// and payloads compared against a word-list reference model of the frame format.
module tb_mipi_payload_framer;

    localparam int          DLEN   = 512;
    localparam int          NWORDS = (DLEN + 47) / 48;
    localparam logic [47:0] MARKER = 48'hA0B0C0A0B0C0;

    logic            tx_pixel_clk = 1'b0;
    logic            rst;
    logic [DLEN-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            frame_start;
    logic            pix_req;
    logic [63:0]     out_data;
    logic            busy;
    logic            frame_done;
    logic [31:0]     seq;

    int              nCompared   = 0;
    int              nMismatched = 0;
    logic [31:0]     expSeq;
    logic [47:0]     expWords[$];
    logic [DLEN-1:0] dirPayload;

    mipi_payload_framer #(.DLEN(DLEN), .MARKER(MARKER)) dut (
        .tx_pixel_clk (tx_pixel_clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .frame_start  (frame_start),
        .pix_req      (pix_req),
        .out_data     (out_data),
        .busy         (busy),
        .frame_done   (frame_done),
        .seq          (seq)
    );

    // Free-running pixel clock.
    always #5 tx_pixel_clk = ~tx_pixel_clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference frame: list of every word the link must carry, built bit by bit from the payload.
    function automatic void buildFrame(input logic [DLEN-1:0] p, input logic [31:0] s);
        logic [47:0] w;
        logic [47:0] cs;
        expWords.delete();
        expWords.push_back(MARKER);
        expWords.push_back({16'(NWORDS), s});
        cs = '0;
        for (int k = 0; k < NWORDS; k++) begin
            w = '0;
            for (int b = 0; b < 48; b++) begin
                if (48 * k + b < DLEN) w[b] = p[48*k+b];
            end
            expWords.push_back(w);
            cs = cs ^ w;
        end
        expWords.push_back(cs);
    endfunction

    function automatic logic [DLEN-1:0] randPayload();
        logic [DLEN-1:0] r;
        for (int j = 0; j < DLEN; j++) r[j] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // One full frame: hand over payload, linger in WAIT_SOF, strobe start, stream with stalls.
    // abortAt >= 0 asserts reset when that frame word index is on the bus.
    task automatic applyStimulus(input logic [DLEN-1:0] p, input int stallPct, input bit noisy,
                                 input bit press, input int abortAt);
        int i;
        int cycles;
        int nWait;
        @(posedge tx_pixel_clk); #1;
        rst         = 1'b0;
        in_valid    = 1'b1;
        in_data     = p;
        pix_req     = 1'($urandom_range(0, 1));
        frame_start = 1'($urandom_range(0, 1));
        @(negedge tx_pixel_clk);
        checkOutput("idleReady", 64'(in_ready), 64'd1);
        checkOutput("idleOut", out_data, 64'd0);
        checkOutput("idleBusy", 64'(busy), 64'd0);
        expSeq = expSeq + 32'd1;
        buildFrame(p, expSeq);

        nWait = $urandom_range(0, 3);
        for (int w = 0; w < nWait; w++) begin
            @(posedge tx_pixel_clk); #1;
            in_valid    = press;
            in_data     = ~p;
            frame_start = 1'b0;
            pix_req     = 1'($urandom_range(0, 1));
            @(negedge tx_pixel_clk);
            checkOutput("sofReady", 64'(in_ready), 64'd0);
            checkOutput("sofFiller", out_data, 64'd0);
            checkOutput("sofBusy", 64'(busy), 64'd1);
        end

        @(posedge tx_pixel_clk); #1;
        in_valid    = press;
        in_data     = ~p;
        frame_start = 1'b1;
        pix_req     = 1'($urandom_range(0, 1));
        @(negedge tx_pixel_clk);
        checkOutput("startFiller", out_data, 64'd0);

        i = 0;
        cycles = 0;
        while (i < expWords.size()) begin
            if (cycles > 500) begin
                checkOutput("timeout", 64'(i), 64'(expWords.size()));
                break;
            end
            @(posedge tx_pixel_clk); #1;
            frame_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            pix_req     = ($urandom_range(0, 99) >= stallPct);
            in_valid    = press;
            in_data     = ~p;
            if (abortAt == i) begin
                rst = 1'b1;
                @(posedge tx_pixel_clk); #1;
                rst         = 1'b0;
                in_valid    = 1'b0;
                frame_start = 1'b0;
                pix_req     = 1'($urandom_range(0, 1));
                @(negedge tx_pixel_clk);
                checkOutput("abortOut", out_data, 64'd0);
                checkOutput("abortReady", 64'(in_ready), 64'd1);
                checkOutput("abortSeq", 64'(seq), 64'd0);
                checkOutput("abortBusy", 64'(busy), 64'd0);
                expSeq = 32'd0;
                return;
            end
            @(negedge tx_pixel_clk);
            checkOutput("word", out_data, {16'h0000, expWords[i]});
            checkOutput("frameDone", 64'(frame_done), 64'(pix_req && (i == expWords.size() - 1)));
            checkOutput("seq", 64'(seq), 64'(expSeq));
            checkOutput("frameBusy", 64'(busy), 64'd1);
            if (pix_req) i++;
            cycles++;
        end

        @(posedge tx_pixel_clk); #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        pix_req     = 1'($urandom_range(0, 1));
        @(negedge tx_pixel_clk);
        checkOutput("endOut", out_data, 64'd0);
        checkOutput("endBusy", 64'(busy), 64'd0);
        checkOutput("endReady", 64'(in_ready), 64'd1);
        checkOutput("endDone", 64'(frame_done), 64'd0);
    endtask

    // Test sequence: reset, directed frame, stalled rerun, busy handshake, random frames, wrap, abort.
    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        frame_start = 1'b0;
        pix_req     = 1'b0;
        expSeq      = 32'd0;
        for (int j = 0; j < 64; j++) dirPayload[(63-j)*8 +: 8] = 8'(j + 1);

        for (int c = 0; c < 3; c++) begin
            @(posedge tx_pixel_clk); #1;
            pix_req     = 1'($urandom_range(0, 1));
            frame_start = 1'($urandom_range(0, 1));
            @(negedge tx_pixel_clk);
            checkOutput("rstOut", out_data, 64'd0);
            checkOutput("rstBusy", 64'(busy), 64'd0);
            checkOutput("rstReady", 64'(in_ready), 64'd0);
            checkOutput("rstSeq", 64'(seq), 64'd0);
        end
        @(posedge tx_pixel_clk); #1;
        rst         = 1'b0;
        pix_req     = 1'b0;
        frame_start = 1'b0;
        @(negedge tx_pixel_clk);
        checkOutput("postRstReady", 64'(in_ready), 64'd1);
        checkOutput("postRstSeq", 64'(seq), 64'd0);

        applyStimulus(dirPayload, 0, 1'b0, 1'b0, -1);
        applyStimulus(dirPayload, 50, 1'b0, 1'b0, -1);
        applyStimulus(randPayload(), 30, 1'b1, 1'b1, -1);
        for (int f = 0; f < 3; f++) begin
            applyStimulus(randPayload(), $urandom_range(0, 60), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), -1);
        end

        force dut.r_seq = 32'hFFFF_FFFF;
        #1;
        release dut.r_seq;
        #1;
        expSeq = 32'hFFFF_FFFF;
        checkOutput("seqPreload", 64'(seq), 64'hFFFF_FFFF);
        applyStimulus(randPayload(), 20, 1'b1, 1'b0, -1);
        applyStimulus(randPayload(), 20, 1'b0, 1'b0, -1);

        applyStimulus(dirPayload, 25, 1'b0, 1'b0, 2 + 5);
        applyStimulus(dirPayload, 0, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
